change_dispenser: RTL

Sequential back end of the vending change path. Consumes the change amount and the exact-amount / not-enough-change flags produced by the combinational change-calculation stage. Pays the change out one coin per handshake from a finite internal coin inventory of denominations 5, 2 and 1. Reports the inventory value back as the `Remaining` input of the not-enough-change check.

---
 rtl/change_dispenser.sv | 124 ++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: pays a change amount out one coin per handshake from a
// finite 5/2/1 coin inventory, using a greedy largest-coin-first pick.
module change_dispenser #(
    parameter int unsigned N5_INIT = 3,
    parameter int unsigned N2_INIT = 3,
    parameter int unsigned N1_INIT = 3
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       start,
    input  logic [3:0] change,
    input  logic       NotEnoughChange,
    input  logic       refill,
    output logic       coin_valid,
    output logic [2:0] coin_denom,
    input  logic       coin_ready,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] left,
    output logic [3:0] Remaining
);

    localparam logic [3:0] N5_RST = 4'(N5_INIT);
    localparam logic [3:0] N2_RST = 4'(N2_INIT);
    localparam logic [3:0] N1_RST = 4'(N1_INIT);

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_e;

    state_e     state_q;
    logic [3:0] n5_q;
    logic [3:0] n2_q;
    logic [3:0] n1_q;
    logic [3:0] left_q;
    logic [3:0] left_d;
    logic       fail_q;
    logic [2:0] pick;
    logic [6:0] total;

    // The pick only uses registered values, so the offered coin is stable while
    // the mechanism stalls; a zero pick means nothing suitable is left.
    always_comb begin
        pick = 3'd0;
        if (left_q >= 4'd5 && n5_q != 4'd0) begin
            pick = 3'd5;
        end else if (left_q >= 4'd2 && n2_q != 4'd0) begin
            pick = 3'd2;
        end else if (n1_q != 4'd0) begin
            pick = 3'd1;
        end
    end

    assign left_d     = left_q - {1'b0, pick};
    assign coin_valid = (state_q == DISPENSE) && (pick != 3'd0);
    assign coin_denom = coin_valid ? pick : 3'd0;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign fail       = (state_q == DONE) && fail_q;
    assign left       = left_q;

    // Inventory can exceed what the 4-bit Remaining can express, hence saturation.
    assign total     = 7'(n5_q) * 7'd5 + 7'(n2_q) * 7'd2 + 7'(n1_q);
    assign Remaining = (total > 7'd15) ? 4'd15 : total[3:0];

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            n5_q    <= N5_RST;
            n2_q    <= N2_RST;
            n1_q    <= N1_RST;
            left_q  <= 4'd0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (refill) begin
                        n5_q <= N5_RST;
                        n2_q <= N2_RST;
                        n1_q <= N1_RST;
                    end else if (start) begin
                        left_q <= change;
                        if (NotEnoughChange) begin
                            fail_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (change == 4'd0) begin
                            fail_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            state_q <= DISPENSE;
                        end
                    end
                end
                DISPENSE: begin
                    if (pick == 3'd0) begin
                        fail_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (coin_ready) begin
                        left_q <= left_d;
                        case (pick)
                            3'd5:    n5_q <= n5_q - 4'd1;
                            3'd2:    n2_q <= n2_q - 4'd1;
                            default: n1_q <= n1_q - 4'd1;
                        endcase
                        if (left_d == 4'd0) begin
                            fail_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
